// File: rtl/cnn_ctrl_pkg.sv
`timescale 1ns/1ps
// Shared control-path types and defaults for CNN layer sequencing.
package cnn_ctrl_pkg;

    localparam int unsigned STATE_W                = 3;
    localparam int unsigned MAX_NUM_LAYERS         = 16;
    localparam int unsigned DEFAULT_NUM_LAYERS     = 2;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 65535;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FINISH = 3'd3,
        ST_ERROR  = 3'd4
    } seq_state_t;

    // Layer index width; a single layer still gets a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_seq_if.sv
`timescale 1ns/1ps
// Launch/completion handshake between a layer sequencer and its CNN layer engines.
interface layer_seq_if
    import cnn_ctrl_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = DEFAULT_NUM_LAYERS
) ();

    localparam int unsigned IDX_W = idx_width(NUM_LAYERS);

    logic                  start;
    logic                  abort;
    logic [NUM_LAYERS-1:0] layer_done;
    logic [NUM_LAYERS-1:0] layer_start;
    logic [IDX_W-1:0]      layer_idx;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output start, abort, layer_done,
        input  layer_start, layer_idx, busy, done, error
    );

    modport slave (
        input  start, abort, layer_done,
        output layer_start, layer_idx, busy, done, error
    );

endinterface

// File: rtl/layer_watchdog.sv
`timescale 1ns/1ps
// Per-layer wait counter; expired marks the last allowed wait cycle.
module layer_watchdog
    import cnn_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // count holds the number of wait cycles already spent on this layer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = en && (count == LIMIT);

endmodule

// File: rtl/layer_sequencer.sv
`timescale 1ns/1ps
// Steps CNN layers 0..NUM_LAYERS-1 through launch/wait/finish with abort.
// Optional per-layer watchdog and ERROR state under LAYER_SEQ_WATCHDOG_EN.
module layer_sequencer
    import cnn_ctrl_pkg::*;
#(
    parameter int unsigned NUM_LAYERS     = DEFAULT_NUM_LAYERS,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input logic        clk,
    input logic        rst_n,
    layer_seq_if.slave bus
);

    localparam int unsigned IDX_W = idx_width(NUM_LAYERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

    if (NUM_LAYERS < 1 || NUM_LAYERS > MAX_NUM_LAYERS || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("layer_sequencer: NUM_LAYERS or TIMEOUT_CYCLES out of range");
    end

    seq_state_t       state;
    logic [IDX_W-1:0] idx;
    logic             done_sel;
    logic             wd_expired;

    // Only the completion bit of the layer currently in flight matters.
    assign done_sel      = bus.layer_done[idx];
    assign bus.layer_idx = idx;

`ifdef LAYER_SEQ_WATCHDOG_EN
    layer_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == ST_LAUNCH),
        .en      (state == ST_WAIT),
        .expired (wd_expired)
    );

    // Sticky until software restarts or aborts out of ERROR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.error <= 1'b0;
        end else if (state == ST_WAIT && !bus.abort && !done_sel && wd_expired) begin
            bus.error <= 1'b1;
        end else if (state == ST_ERROR && (bus.start || bus.abort)) begin
            bus.error <= 1'b0;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign bus.error  = 1'b0;
`endif

    // State, index and registered launch/done/busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            idx             <= '0;
            bus.layer_start <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            bus.layer_start <= '0;
            bus.done        <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state           <= ST_LAUNCH;
                        idx             <= '0;
                        bus.layer_start <= NUM_LAYERS'(1);
                        bus.busy        <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    if (bus.abort) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // abort beats completion, completion beats the watchdog
                    if (bus.abort) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end else if (done_sel) begin
                        if (idx == LAST_IDX) begin
                            state    <= ST_FINISH;
                            bus.done <= 1'b1;
                        end else begin
                            state           <= ST_LAUNCH;
                            idx             <= idx + IDX_W'(1);
                            bus.layer_start <= NUM_LAYERS'(1) << (idx + IDX_W'(1));
                        end
                    end else if (wd_expired) begin
                        state    <= ST_ERROR;
                        bus.busy <= 1'b0;
                    end
                end
                ST_FINISH: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
                ST_ERROR: begin
                    if (bus.abort) begin
                        state <= ST_IDLE;
                    end else if (bus.start) begin
                        state           <= ST_LAUNCH;
                        idx             <= '0;
                        bus.layer_start <= NUM_LAYERS'(1);
                        bus.busy        <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
`timescale 1ns/1ps
// Directed and random checks of layer_sequencer against a pass-level reference model.
module tb_layer_sequencer;

    localparam int unsigned NA = 4;
    localparam int unsigned NB = 2;
    localparam int unsigned TO = 8;
`ifdef LAYER_SEQ_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    layer_seq_if #(.NUM_LAYERS(NA)) bus_a ();
    layer_seq_if #(.NUM_LAYERS(NB)) bus_b ();

    layer_sequencer #(.NUM_LAYERS(NA), .TIMEOUT_CYCLES(TO)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    layer_sequencer #(.NUM_LAYERS(NB), .TIMEOUT_CYCLES(TO)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    int nvec = 0;
    int nerr = 0;

    // Pass-level model: is a pass running, which layer, launching/finishing this cycle.
    bit m_busy;
    int m_launch;
    int m_layer;
    bit m_fin;
    int m_waited;
    bit m_err;

    int starts_seen;
    int dones_seen;
    int idx_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_launch = -1; m_layer = 0; m_fin = 1'b0; m_waited = 0; m_err = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit a, input logic [NA-1:0] ld);
        if (!m_busy) begin
            if (m_err && a) begin
                m_err = 1'b0;
            end else if (s) begin
                m_err = 1'b0; m_busy = 1'b1; m_layer = 0; m_launch = 0;
            end
        end else if (m_launch >= 0) begin
            m_launch = -1;
            m_waited = 0;
            if (a) m_busy = 1'b0;
        end else if (m_fin) begin
            m_fin  = 1'b0;
            m_busy = 1'b0;
        end else if (a) begin
            m_busy = 1'b0;
        end else if (ld[m_layer]) begin
            if (m_layer == int'(NA) - 1) begin
                m_fin = 1'b1;
            end else begin
                m_layer++;
                m_launch = m_layer;
            end
        end else begin
            m_waited++;
            if (WD && m_waited == int'(TO)) begin
                m_err = 1'b1; m_busy = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        check("layer_start", 32'(bus_a.layer_start), (m_launch >= 0) ? (32'd1 << m_launch) : 32'd0);
        check("start_onehot", 32'($onehot0(bus_a.layer_start)), 32'd1);
        check("layer_idx", 32'(bus_a.layer_idx), 32'(m_layer));
        check("busy", 32'(bus_a.busy), 32'(m_busy));
        check("done", 32'(bus_a.done), 32'(m_fin));
        check("error", 32'(bus_a.error), 32'(m_err));
        if (bus_a.layer_start != '0) begin
            starts_seen++;
            idx_log.push_back(int'(bus_a.layer_idx));
        end
        if (bus_a.done) dones_seen++;
    endtask

    // Check this cycle, drive the next inputs, advance the model by one clock.
    task automatic cyc(input bit s, input bit a, input logic [NA-1:0] ld);
        check_outputs();
        bus_a.start = s;
        bus_a.abort = a;
        bus_a.layer_done = ld;
        model_step(s, a, ld);
        @(negedge clk);
    endtask

    task automatic clear_tally();
        starts_seen = 0;
        dones_seen  = 0;
        idx_log.delete();
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.layer_done = '0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.layer_done = '0;
        model_reset();
        clear_tally();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0000);

        // Two-layer reference timeline on the second instance.
        for (int c = 0; c <= 12; c++) begin
            check("b_layer_start", 32'(bus_b.layer_start), (c == 1) ? 32'd1 : (c == 6) ? 32'd2 : 32'd0);
            check("b_done", 32'(bus_b.done), 32'(c == 10));
            check("b_busy", 32'(bus_b.busy), 32'(c >= 1 && c <= 10));
            bus_b.start = (c == 0);
            bus_b.layer_done = (c == 5) ? 2'b01 : (c == 9) ? 2'b10 : 2'b00;
            @(negedge clk);
        end

        // Full four-layer pass, completion three cycles after each launch.
        clear_tally();
        cyc(1'b1, 1'b0, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            repeat (3) cyc(1'b0, 1'b0, 4'b0000);
            cyc(1'b0, 1'b0, 4'(1 << k));
        end
        cyc(1'b0, 1'b0, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0000);
        check("pass_starts", 32'(starts_seen), 32'd4);
        check("pass_dones", 32'(dones_seen), 32'd1);
        for (int i = 0; i < 4; i++)
            check("idx_step", (i < idx_log.size()) ? 32'(idx_log[i]) : 32'hffff_ffff, 32'(i));

        // Abort together with layer 0 completion.
        clear_tally();
        cyc(1'b1, 1'b0, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0000);
        cyc(1'b0, 1'b1, 4'b0001);
        check("abort_busy", 32'(bus_a.busy), 32'd0);
        cyc(1'b0, 1'b0, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0000);
        check("abort_starts", 32'(starts_seen), 32'd1);
        check("abort_dones", 32'(dones_seen), 32'd0);
        cyc(1'b1, 1'b0, 4'b0000);
        check("restart_start", 32'(bus_a.layer_start), 32'd1);
        check("restart_idx", 32'(bus_a.layer_idx), 32'd0);

        // Wrong-layer done and start while busy are both ignored.
        cyc(1'b0, 1'b0, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0010);
        cyc(1'b1, 1'b0, 4'b0000);
        check("ignore_idx", 32'(bus_a.layer_idx), 32'd0);
        check("ignore_busy", 32'(bus_a.busy), 32'd1);
        check("ignore_start", 32'(bus_a.layer_start), 32'd0);
        cyc(1'b0, 1'b1, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0000);

        // Watchdog timeout (or indefinite wait when no watchdog is built).
        cyc(1'b1, 1'b0, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0000);
        repeat (TO) cyc(1'b0, 1'b0, 4'b0000);
        check("wd_error", 32'(bus_a.error), 32'(WD));
        check("wd_busy", 32'(bus_a.busy), 32'(!WD));
        cyc(1'b1, 1'b0, 4'b0000);
        check("wd_clear", 32'(bus_a.error), 32'd0);
        check("wd_relaunch", 32'(bus_a.layer_start), WD ? 32'd1 : 32'd0);
        cyc(1'b0, 1'b1, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0000);

        // Completion on the limit cycle beats the timeout.
        cyc(1'b1, 1'b0, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0000);
        repeat (TO - 1) cyc(1'b0, 1'b0, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0001);
        check("limit_win_err", 32'(bus_a.error), 32'd0);
        check("limit_win_start", 32'(bus_a.layer_start), 32'd2);
        cyc(1'b0, 1'b1, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0000);

        // Asynchronous reset while waiting on layer 1.
        cyc(1'b1, 1'b0, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0001);
        cyc(1'b0, 1'b0, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0000);
        check("pre_rst_idx", 32'(bus_a.layer_idx), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_start", 32'(bus_a.layer_start), 32'd0);
        check("rst_idx", 32'(bus_a.layer_idx), 32'd0);
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        check("rst_done", 32'(bus_a.done), 32'd0);
        check("rst_error", 32'(bus_a.error), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        @(negedge clk);
        clear_tally();
        repeat (5) cyc(1'b0, 1'b0, 4'b0000);
        check("post_rst_quiet", 32'(starts_seen), 32'd0);

        // Random traffic against the model.
        repeat (800) begin
            cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 29) == 0),
                4'($urandom) & 4'($urandom));
        end
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
